// File: rtl/scfifo_mixed_gen.sv
// Single-clock FIFO with a power-of-2 width ratio in either direction.
// Storage is held as W_MIN-wide units so both ports index the same lanes.
module scfifo_mixed_gen #(
    parameter int    WIDTH_IN        = 512,
    parameter int    WIDTH_OUT       = 128,
    parameter int    DEPTH           = 8,
    parameter string SHOWAHEAD       = "OFF",
    parameter int    LSB_FIRST       = 1,
    parameter int    ALMOST_FULL_TH  = DEPTH - 1,
    parameter int    ALMOST_EMPTY_TH = 1,
    localparam int   W_MIN = (WIDTH_IN < WIDTH_OUT) ? WIDTH_IN : WIDTH_OUT,
    localparam int   R_IN  = WIDTH_IN / W_MIN,
    localparam int   R_OUT = WIDTH_OUT / W_MIN,
    localparam int   UNITS = DEPTH * R_IN,
    localparam int   WU_W  = $clog2(DEPTH) + 1,
    localparam int   RU_W  = $clog2(UNITS / R_OUT) + 1
) (
    input  logic                 clk_i,
    input  logic                 aclr_n_i,
    input  logic                 sclr_i,
    input  logic [WIDTH_IN-1:0]  data_i,
    input  logic                 wrreq_i,
    input  logic                 rdreq_i,
    output logic [WIDTH_OUT-1:0] q_o,
    output logic                 rdempty_o,
    output logic                 wrfull_o,
    output logic                 almost_full_o,
    output logic                 almost_empty_o,
    output logic [WU_W-1:0]      wrusedw_o,
    output logic [RU_W-1:0]      rdusedw_o,
    output logic                 overflow_o,
    output logic                 underflow_o
);

    localparam int PW      = $clog2(UNITS) + 1;
    localparam int UW      = $clog2(UNITS);
    localparam int LG_RIN  = $clog2(R_IN);
    localparam int LG_ROUT = $clog2(R_OUT);
    localparam bit SHOW_ON = (SHOWAHEAD == "ON");

    logic [W_MIN-1:0]     mem_q [UNITS];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;
    logic [PW-1:0]        count;
    logic [PW-1:0]        wu_sum;
    logic                 wr_acc, rd_acc;
    logic [W_MIN-1:0]     wr_unit [R_IN];
    logic [WIDTH_OUT-1:0] rd_word;
    logic [UW-1:0]        wr_idx, rd_idx;

    // Pointers run modulo 2*UNITS so count spans the full 0..UNITS range.
    assign count     = wr_ptr_q - rd_ptr_q;
    assign wu_sum    = count + PW'(R_IN - 1);
    assign rdempty_o = count < PW'(R_OUT);
    assign wrfull_o  = (PW'(UNITS) - count) < PW'(R_IN);
    assign wrusedw_o = WU_W'(wu_sum >> LG_RIN);
    assign rdusedw_o = RU_W'(count >> LG_ROUT);

    assign almost_full_o  = int'(wrusedw_o) >= ALMOST_FULL_TH;
    assign almost_empty_o = int'(rdusedw_o) < ALMOST_EMPTY_TH;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

    assign wr_acc = wrreq_i & ~wrfull_o;
    assign rd_acc = rdreq_i & ~rdempty_o;
    assign wr_idx = wr_ptr_q[UW-1:0];
    assign rd_idx = rd_ptr_q[UW-1:0];

    always_comb begin
        for (int k = 0; k < R_IN; k++) begin
            wr_unit[k] = (LSB_FIRST != 0) ? data_i[k*W_MIN +: W_MIN]
                                          : data_i[(R_IN-1-k)*W_MIN +: W_MIN];
        end
    end

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < R_OUT; k++) begin
            if (LSB_FIRST != 0) begin
                rd_word[k*W_MIN +: W_MIN] = mem_q[rd_idx + UW'(k)];
            end else begin
                rd_word[(R_OUT-1-k)*W_MIN +: W_MIN] = mem_q[rd_idx + UW'(k)];
            end
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q | (wrreq_i & wrfull_o);
        underflow_d = underflow_q | (rdreq_i & rdempty_o);
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PW'(R_IN);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PW'(R_OUT);
        end
        if (sclr_i) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge aclr_n_i) begin
        if (!aclr_n_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Memory is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (wr_acc && !sclr_i) begin
            for (int k = 0; k < R_IN; k++) begin
                mem_q[wr_idx + UW'(k)] <= wr_unit[k];
            end
        end
    end

    generate
        if (SHOW_ON) begin : g_show
            assign q_o = rdempty_o ? '0 : rd_word;
        end else begin : g_reg
            logic [WIDTH_OUT-1:0] q_q, q_d;

            always_comb begin
                q_d = q_q;
                if (rd_acc) begin
                    q_d = rd_word;
                end
                if (sclr_i) begin
                    q_d = '0;
                end
            end

            always_ff @(posedge clk_i or negedge aclr_n_i) begin
                if (!aclr_n_i) begin
                    q_q <= '0;
                end else begin
                    q_q <= q_d;
                end
            end

            assign q_o = q_q;
        end
    endgenerate

endmodule

// File: tb/tb_scfifo_mixed_gen.sv
// Bench for scfifo_mixed_gen: directed steps plus random traffic on a default
// narrowing instance, with a unit-queue reference model; small widening/MSB-first instances.
module tb_scfifo_mixed_gen;

    localparam logic [127:0] LA = 128'hAAAA0001_AAAA0002_AAAA0003_AAAA0004;
    localparam logic [127:0] LB = 128'hBBBB0001_BBBB0002_BBBB0003_BBBB0004;
    localparam logic [127:0] LC = 128'hCCCC0001_CCCC0002_CCCC0003_CCCC0004;
    localparam logic [127:0] LD = 128'hDDDD0001_DDDD0002_DDDD0003_DDDD0004;

    logic clk;
    logic aclr_n;

    // default narrowing instance (512 -> 128, OFF, LSB first)
    logic         n_sclr, n_wrreq, n_rdreq;
    logic [511:0] n_data;
    logic [127:0] n_q;
    logic         n_rdempty, n_wrfull, n_af, n_ae, n_ovf, n_udf;
    logic [3:0]   n_wrusedw;
    logic [5:0]   n_rdusedw;

    // widening instance (32 -> 128, ON)
    logic         w_sclr, w_wrreq, w_rdreq;
    logic [31:0]  w_data;
    logic [127:0] w_q;
    logic         w_rdempty, w_wrfull, w_af, w_ae, w_ovf, w_udf;
    logic [3:0]   w_wrusedw;
    logic [1:0]   w_rdusedw;

    // MSB-first narrowing instance
    logic         m_sclr, m_wrreq, m_rdreq;
    logic [511:0] m_data;
    logic [127:0] m_q;
    logic         m_rdempty, m_wrfull, m_af, m_ae, m_ovf, m_udf;
    logic [3:0]   m_wrusedw;
    logic [5:0]   m_rdusedw;

    int n_assert = 0;
    int n_fail   = 0;

    logic [127:0] mdl[$];
    logic         mdl_ovf, mdl_udf;
    logic [127:0] mdl_q;
    logic [127:0] saved_q;

    scfifo_mixed_gen u_nar (
        .clk_i(clk), .aclr_n_i(aclr_n), .sclr_i(n_sclr), .data_i(n_data),
        .wrreq_i(n_wrreq), .rdreq_i(n_rdreq), .q_o(n_q), .rdempty_o(n_rdempty),
        .wrfull_o(n_wrfull), .almost_full_o(n_af), .almost_empty_o(n_ae),
        .wrusedw_o(n_wrusedw), .rdusedw_o(n_rdusedw), .overflow_o(n_ovf),
        .underflow_o(n_udf)
    );

    scfifo_mixed_gen #(
        .WIDTH_IN(32), .WIDTH_OUT(128), .DEPTH(8), .SHOWAHEAD("ON")
    ) u_wid (
        .clk_i(clk), .aclr_n_i(aclr_n), .sclr_i(w_sclr), .data_i(w_data),
        .wrreq_i(w_wrreq), .rdreq_i(w_rdreq), .q_o(w_q), .rdempty_o(w_rdempty),
        .wrfull_o(w_wrfull), .almost_full_o(w_af), .almost_empty_o(w_ae),
        .wrusedw_o(w_wrusedw), .rdusedw_o(w_rdusedw), .overflow_o(w_ovf),
        .underflow_o(w_udf)
    );

    scfifo_mixed_gen #(
        .LSB_FIRST(0)
    ) u_msb (
        .clk_i(clk), .aclr_n_i(aclr_n), .sclr_i(m_sclr), .data_i(m_data),
        .wrreq_i(m_wrreq), .rdreq_i(m_rdreq), .q_o(m_q), .rdempty_o(m_rdempty),
        .wrfull_o(m_wrfull), .almost_full_o(m_af), .almost_empty_o(m_ae),
        .wrusedw_o(m_wrusedw), .rdusedw_o(m_rdusedw), .overflow_o(m_ovf),
        .underflow_o(m_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_n(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model view of u_nar: 32 units of 128 bits, 4 units per write, 1 per read.
    task automatic check_main(input string tag);
        int cnt;
        cnt = mdl.size();
        chk_b({tag, ".rdempty"},  n_rdempty, cnt < 1);
        chk_b({tag, ".wrfull"},   n_wrfull, (32 - cnt) < 4);
        chk_n({tag, ".wrusedw"},  int'(n_wrusedw), (cnt + 3) / 4);
        chk_n({tag, ".rdusedw"},  int'(n_rdusedw), cnt);
        chk_b({tag, ".afull"},    n_af, ((cnt + 3) / 4) >= 7);
        chk_b({tag, ".aempty"},   n_ae, cnt < 1);
        chk_b({tag, ".overflow"}, n_ovf, mdl_ovf);
        chk_b({tag, ".underflow"}, n_udf, mdl_udf);
        chk_w({tag, ".q"},        n_q, mdl_q);
    endtask

    task automatic step(input logic w, input logic r, input logic s,
                        input logic [511:0] d, input string tag);
        int cnt;
        cnt = mdl.size();
        n_wrreq = w;
        n_rdreq = r;
        n_sclr  = s;
        n_data  = d;
        if (s) begin
            mdl.delete();
            mdl_ovf = 1'b0;
            mdl_udf = 1'b0;
            mdl_q   = '0;
        end else begin
            if (w && (32 - cnt) < 4) mdl_ovf = 1'b1;
            if (r && cnt < 1) mdl_udf = 1'b1;
            if (r && cnt >= 1) mdl_q = mdl.pop_front();
            if (w && (32 - cnt) >= 4) begin
                for (int k = 0; k < 4; k++) mdl.push_back(d[k*128 +: 128]);
            end
        end
        tick();
        n_wrreq = 1'b0;
        n_rdreq = 1'b0;
        n_sclr  = 1'b0;
        check_main(tag);
    endtask

    task automatic model_reset();
        mdl.delete();
        mdl_ovf = 1'b0;
        mdl_udf = 1'b0;
        mdl_q   = '0;
    endtask

    initial begin
        aclr_n = 1'b0;
        n_sclr = 0; n_wrreq = 0; n_rdreq = 0; n_data = '0;
        w_sclr = 0; w_wrreq = 0; w_rdreq = 0; w_data = '0;
        m_sclr = 0; m_wrreq = 0; m_rdreq = 0; m_data = '0;
        model_reset();

        #3;
        chk_b("inrst.rdempty", n_rdempty, 1'b1);
        chk_b("inrst.aempty", n_ae, 1'b1);
        #14 aclr_n = 1'b1;
        tick();
        check_main("rst");
        chk_w("msb.rst.q", m_q, 128'h0);

        // widening, show-ahead
        for (int i = 1; i <= 3; i++) begin
            w_data = 32'(i);
            w_wrreq = 1'b1;
            tick();
            chk_b("wid.partial.rdempty", w_rdempty, 1'b1);
            chk_n("wid.partial.rdusedw", int'(w_rdusedw), 0);
        end
        w_data = 32'd4;
        tick();
        w_wrreq = 1'b0;
        chk_b("wid.ready.rdempty", w_rdempty, 1'b0);
        chk_w("wid.ready.q", w_q, 128'h00000004_00000003_00000002_00000001);
        chk_n("wid.ready.wrusedw", int'(w_wrusedw), 4);
        for (int i = 5; i <= 8; i++) begin
            w_data = 32'(i);
            w_wrreq = 1'b1;
            tick();
        end
        w_wrreq = 1'b0;
        chk_b("wid.full.wrfull", w_wrfull, 1'b1);
        chk_n("wid.full.rdusedw", int'(w_rdusedw), 2);
        chk_w("wid.full.q_head", w_q, 128'h00000004_00000003_00000002_00000001);
        w_rdreq = 1'b1;
        tick();
        chk_w("wid.rd1.q", w_q, 128'h00000008_00000007_00000006_00000005);
        chk_b("wid.rd1.wrfull", w_wrfull, 1'b0);
        chk_n("wid.rd1.rdusedw", int'(w_rdusedw), 1);
        tick();
        w_rdreq = 1'b0;
        chk_b("wid.rd2.rdempty", w_rdempty, 1'b1);
        chk_b("wid.rd2.aempty", w_ae, 1'b1);

        // MSB-first narrowing
        m_data = {LD, LC, LB, LA};
        m_wrreq = 1'b1;
        tick();
        m_wrreq = 1'b0;
        chk_b("msb.wr.rdempty", m_rdempty, 1'b0);
        m_rdreq = 1'b1;
        tick(); chk_w("msb.rd0.q", m_q, LD);
        tick(); chk_w("msb.rd1.q", m_q, LC);
        tick(); chk_w("msb.rd2.q", m_q, LB);
        tick(); chk_w("msb.rd3.q", m_q, LA);
        m_rdreq = 1'b0;
        tick();
        chk_w("msb.hold.q", m_q, LA);
        chk_b("msb.hold.rdempty", m_rdempty, 1'b1);

        // default narrowing: one word out as four lanes
        step(1, 0, 0, {LD, LC, LB, LA}, "nar.wr");
        chk_n("nar.wr.wrusedw", int'(n_wrusedw), 1);
        chk_n("nar.wr.rdusedw", int'(n_rdusedw), 4);
        step(0, 1, 0, '0, "nar.rd0");
        chk_w("nar.rd0.q", n_q, LA);
        chk_n("nar.rd0.wrusedw", int'(n_wrusedw), 1);
        step(0, 1, 0, '0, "nar.rd1");
        chk_w("nar.rd1.q", n_q, LB);
        step(0, 1, 0, '0, "nar.rd2");
        chk_w("nar.rd2.q", n_q, LC);
        chk_n("nar.rd2.wrusedw", int'(n_wrusedw), 1);
        step(0, 1, 0, '0, "nar.rd3");
        chk_w("nar.rd3.q", n_q, LD);
        chk_n("nar.rd3.wrusedw", int'(n_wrusedw), 0);
        chk_b("nar.rd3.rdempty", n_rdempty, 1'b1);

        // fill to full, then overflow
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0, rnd512(), "fill");
            if (i == 5) chk_b("fill6.afull", n_af, 1'b0);
            if (i == 6) chk_b("fill7.afull", n_af, 1'b1);
        end
        chk_b("full.wrfull", n_wrfull, 1'b1);
        chk_n("full.wrusedw", int'(n_wrusedw), 8);
        step(1, 0, 0, rnd512(), "ovf");
        chk_b("ovf.overflow", n_ovf, 1'b1);
        chk_n("ovf.wrusedw", int'(n_wrusedw), 8);
        for (int i = 0; i < 32; i++) step(0, 1, 0, '0, "drain");

        saved_q = mdl_q;
        step(0, 1, 0, '0, "udf");
        chk_b("udf.underflow", n_udf, 1'b1);
        chk_w("udf.q_hold", n_q, saved_q);

        // simultaneous write and read with one word stored
        step(0, 0, 1, '0, "clr");
        step(1, 0, 0, rnd512(), "sim.pre");
        chk_n("sim.pre.rdusedw", int'(n_rdusedw), 4);
        step(1, 1, 0, rnd512(), "sim");
        chk_n("sim.rdusedw", int'(n_rdusedw), 7);

        // asynchronous reset mid-operation
        step(0, 0, 1, '0, "clr2");
        for (int i = 0; i < 5; i++) step(1, 0, 0, rnd512(), "mid.wr");
        for (int i = 0; i < 3; i++) step(0, 1, 0, '0, "mid.rd");
        #2 aclr_n = 1'b0;
        #1;
        model_reset();
        chk_b("arst.rdempty", n_rdempty, 1'b1);
        chk_b("arst.wrfull", n_wrfull, 1'b0);
        chk_n("arst.wrusedw", int'(n_wrusedw), 0);
        chk_n("arst.rdusedw", int'(n_rdusedw), 0);
        chk_w("arst.q", n_q, 128'h0);
        check_main("arst");
        #1 aclr_n = 1'b1;
        tick();

        // sync clear wins over a simultaneous write
        step(1, 0, 0, rnd512(), "sc.wr0");
        step(1, 0, 0, rnd512(), "sc.wr1");
        step(1, 0, 1, rnd512(), "sc");
        chk_n("sc.rdusedw", int'(n_rdusedw), 0);
        chk_n("sc.wrusedw", int'(n_wrusedw), 0);
        chk_b("sc.rdempty", n_rdempty, 1'b1);

        // random traffic: write-heavy then read-heavy
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < ((i < 200) ? 60 : 30),
                 $urandom_range(0, 99) < ((i < 200) ? 30 : 60),
                 $urandom_range(0, 99) < 2,
                 rnd512(), "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
